// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefDepth = 4;
    // Instruction shown to decode while the queue is empty.
    localparam logic [15:0] NopInst = 16'h0800;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StDiscard = 2'd2,
        StFault   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// I-cache request/response bus between the fetch queue and the cache.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) ();

    logic             mem_rd;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_stall;
    logic             mem_done;
    logic [WIDTH-1:0] mem_data;
    logic             mem_err;

    // Fetch side issues requests.
    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_stall,
        input  mem_done,
        input  mem_data,
        input  mem_err
    );

    // Cache side answers them.
    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_stall,
        output mem_done,
        output mem_data,
        output mem_err
    );

endinterface

// File: rtl/inst_fifo.sv
// Circular instruction buffer holding {inst, pc_inc} pairs, with synchronous flush.
module inst_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             inst_i,
    input  logic [WIDTH-1:0]             pc_inc_i,
    output logic [WIDTH-1:0]             inst_o,
    output logic [WIDTH-1:0]             pc_inc_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] inst_mem_q [DEPTH];
    logic [WIDTH-1:0] inst_mem_d [DEPTH];
    logic [WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [WIDTH-1:0] pc_mem_d   [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CntW'(DEPTH));
    assign count_o  = count_q;
    assign inst_o   = inst_mem_q[rd_ptr_q];
    assign pc_inc_o = pc_mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap since DEPTH is 2^n.
    always_comb begin
        push_ok    = push_i && !full_o;
        pop_ok     = pop_i && !empty_o;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                inst_mem_d[wr_ptr_q] = inst_i;
                pc_mem_d[wr_ptr_q]   = pc_inc_i;
                wr_ptr_d             = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CntW'(1);
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_mem_q <= '{default: '0};
            pc_mem_q   <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one-outstanding I-cache requester feeding a small queue.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = DefWidth,
    parameter int unsigned      DEPTH    = DefDepth,
    parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(NopInst)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    input  logic                       halt,
    fetch_queue_if.master              mem,
    input  logic                       dec_ready,
    output logic [WIDTH-1:0]           inst,
    output logic [WIDTH-1:0]           inst_pc_inc,
    output logic                       inst_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int unsigned CntW = $clog2(DEPTH+1);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] fpc_q, fpc_d;
    logic             err_q, err_d;
    logic             mem_rd_q, mem_rd_d;
    logic             push, pop, flush;
    logic [WIDTH-1:0] fpc_inc;
    logic [WIDTH-1:0] head_inst, head_pc_inc;
    logic             fifo_empty, fifo_full;
    logic [CntW-1:0]  fifo_count;

    // Wraps modulo 2^WIDTH by construction.
    assign fpc_inc = fpc_q + WIDTH'(2);

    // Next-state: redirect outranks push/pop; FAULT only drains.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        err_d   = err_q;
        push    = 1'b0;
        flush   = 1'b0;
        pop     = !fifo_empty && dec_ready && (!redirect || state_q == StFault);
        if (state_q != StFault && redirect) begin
            flush = 1'b1;
            if (redirect_pc[0]) begin
                err_d   = 1'b1;
                state_d = StFault;
            end else begin
                fpc_d = redirect_pc;
                // A request still in flight must be absorbed before issuing a new one.
                if ((state_q == StReq || state_q == StDiscard) && !mem.mem_done) begin
                    state_d = StDiscard;
                end else begin
                    state_d = StIdle;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fifo_count < CntW'(DEPTH) && !halt) begin
                        state_d = StReq;
                    end
                end
                StReq: begin
                    if (mem.mem_done) begin
                        if (mem.mem_err) begin
                            err_d   = 1'b1;
                            state_d = StFault;
                        end else begin
                            push    = 1'b1;
                            fpc_d   = fpc_inc;
                            state_d = StIdle;
                        end
                    end
                end
                StDiscard: begin
                    if (mem.mem_done) begin
                        state_d = StIdle;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
        mem_rd_d = (state_d == StReq) || (state_d == StDiscard);
    end

    // Register FSM state and outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            fpc_q    <= '0;
            err_q    <= 1'b0;
            mem_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            err_q    <= err_d;
            mem_rd_q <= mem_rd_d;
        end
    end

    inst_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush),
        .push_i   (push),
        .pop_i    (pop),
        .inst_i   (mem.mem_data),
        .pc_inc_i (fpc_inc),
        .inst_o   (head_inst),
        .pc_inc_o (head_pc_inc),
        .count_o  (fifo_count),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_addr = fpc_q;
    assign inst_valid   = !fifo_empty;
    assign inst         = fifo_empty ? NOP_INST : head_inst;
    assign inst_pc_inc  = fifo_empty ? '0 : head_pc_inc;
    assign count        = fifo_count;
    assign err          = err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        dec_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc_inc;
    logic        inst_valid;
    logic [2:0]  count;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue_if #(.WIDTH(16)) mem_bus ();

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .mem         (mem_bus),
        .dec_ready   (dec_ready),
        .inst        (inst),
        .inst_pc_inc (inst_pc_inc),
        .inst_valid  (inst_valid),
        .count       (count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are looked at 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait a bounded number of edges for a request to appear.
    task automatic wait_rd(input string tag);
        int n = 0;
        while (!mem_bus.mem_rd && n < 16) begin
            tick();
            n++;
        end
        check_eq(tag, {31'b0, mem_bus.mem_rd}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1);
    end

    initial begin
        rst                = 1'b1;
        redirect           = 1'b0;
        redirect_pc        = '0;
        halt               = 1'b0;
        dec_ready          = 1'b1;
        mem_bus.mem_stall  = 1'b0;
        mem_bus.mem_done   = 1'b0;
        mem_bus.mem_data   = '0;
        mem_bus.mem_err    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_inst",   {16'b0, inst}, {16'b0, NopInst});
        check_eq("rst_valid",  {31'b0, inst_valid}, 32'd0);
        check_eq("rst_pc_inc", {16'b0, inst_pc_inc}, 32'd0);
        check_eq("rst_mem_rd", {31'b0, mem_bus.mem_rd}, 32'd0);
        check_eq("rst_err",    {31'b0, err}, 32'd0);
        check_eq("rst_count",  {29'b0, count}, 32'd0);

        // Scenario 1: first fetch at 0, two stall cycles.
        tick();
        check_eq("s1_rd",   {31'b0, mem_bus.mem_rd}, 32'd1);
        check_eq("s1_addr", {16'b0, mem_bus.mem_addr}, 32'h0000);
        mem_bus.mem_stall = 1'b1;
        tick();
        tick();
        check_eq("s1_hold_addr", {16'b0, mem_bus.mem_addr}, 32'h0000);
        mem_bus.mem_stall = 1'b0;
        mem_bus.mem_done  = 1'b1;
        mem_bus.mem_data  = 16'h1111;
        #1;
        check_eq("s1_no_bypass", {31'b0, inst_valid}, 32'd0);
        tick();
        mem_bus.mem_done = 1'b0;
        check_eq("s1_inst",   {16'b0, inst}, 32'h1111);
        check_eq("s1_pc_inc", {16'b0, inst_pc_inc}, 32'h0002);
        check_eq("s1_valid",  {31'b0, inst_valid}, 32'd1);
        check_eq("s1_rd_off", {31'b0, mem_bus.mem_rd}, 32'd0);
        tick();
        check_eq("s1_popped", {29'b0, count}, 32'd0);
        check_eq("s1_next",   {16'b0, mem_bus.mem_addr}, 32'h0002);

        // Scenario 2: decode stalled, cache answers every request at once.
        dec_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_bus.mem_done = mem_bus.mem_rd;
            mem_bus.mem_data = 16'hA000 + mem_bus.mem_addr;
            tick();
        end
        mem_bus.mem_done = 1'b0;
        check_eq("s2_count", {29'b0, count}, 32'd4);
        check_eq("s2_rd",    {31'b0, mem_bus.mem_rd}, 32'd0);
        check_eq("s2_head",  {16'b0, inst}, 32'hA002);
        check_eq("s2_pc",    {16'b0, inst_pc_inc}, 32'h0004);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check_eq("s2_pop_count", {29'b0, count}, 32'd3);
        check_eq("s2_pop_inst",  {16'b0, inst}, 32'hA004);
        check_eq("s2_pop_pc",    {16'b0, inst_pc_inc}, 32'h0006);

        // Scenario 3: redirect while the request is stalled.
        wait_rd("s3_wait_rd");
        check_eq("s3_addr", {16'b0, mem_bus.mem_addr}, 32'h000A);
        mem_bus.mem_stall = 1'b1;
        tick();
        check_eq("s3_stall_addr", {16'b0, mem_bus.mem_addr}, 32'h000A);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check_eq("s3_flush",      {29'b0, count}, 32'd0);
        check_eq("s3_disc_rd",    {31'b0, mem_bus.mem_rd}, 32'd1);
        check_eq("s3_nop",        {16'b0, inst}, {16'b0, NopInst});
        tick();
        mem_bus.mem_stall = 1'b0;
        mem_bus.mem_done  = 1'b1;
        mem_bus.mem_data  = 16'hDEAD;
        tick();
        mem_bus.mem_done = 1'b0;
        check_eq("s3_dropped", {31'b0, inst_valid}, 32'd0);
        check_eq("s3_idle_rd", {31'b0, mem_bus.mem_rd}, 32'd0);
        tick();
        check_eq("s3_new_rd",   {31'b0, mem_bus.mem_rd}, 32'd1);
        check_eq("s3_new_addr", {16'b0, mem_bus.mem_addr}, 32'h0040);

        // Scenario 4: redirect coincides with mem_done.
        mem_bus.mem_done = 1'b1;
        mem_bus.mem_data = 16'hBEEF;
        redirect         = 1'b1;
        redirect_pc      = 16'h0100;
        tick();
        mem_bus.mem_done = 1'b0;
        redirect         = 1'b0;
        check_eq("s4_no_push", {29'b0, count}, 32'd0);
        check_eq("s4_rd_off",  {31'b0, mem_bus.mem_rd}, 32'd0);
        tick();
        check_eq("s4_rd",   {31'b0, mem_bus.mem_rd}, 32'd1);
        check_eq("s4_addr", {16'b0, mem_bus.mem_addr}, 32'h0100);
        mem_bus.mem_done = 1'b1;
        mem_bus.mem_data = 16'h1234;
        tick();
        mem_bus.mem_done = 1'b0;
        check_eq("s4_inst", {16'b0, inst}, 32'h1234);
        check_eq("s4_pc",   {16'b0, inst_pc_inc}, 32'h0102);

        // Scenario 6: PC wraps from FFFE to 0000 without error.
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        check_eq("s6_flush", {29'b0, count}, 32'd0);
        wait_rd("s6_wait_rd");
        check_eq("s6_addr", {16'b0, mem_bus.mem_addr}, 32'hFFFE);
        mem_bus.mem_done = 1'b1;
        mem_bus.mem_data = 16'h5678;
        tick();
        mem_bus.mem_done = 1'b0;
        check_eq("s6_inst", {16'b0, inst}, 32'h5678);
        check_eq("s6_pc",   {16'b0, inst_pc_inc}, 32'h0000);
        check_eq("s6_err",  {31'b0, err}, 32'd0);
        wait_rd("s6_wait_rd2");
        check_eq("s6_wrap_addr", {16'b0, mem_bus.mem_addr}, 32'h0000);

        // Scenario 5: error response, then drain and ignore redirect.
        mem_bus.mem_done = 1'b1;
        mem_bus.mem_err  = 1'b1;
        mem_bus.mem_data = 16'hFFFF;
        tick();
        mem_bus.mem_done = 1'b0;
        mem_bus.mem_err  = 1'b0;
        check_eq("s5_err",   {31'b0, err}, 32'd1);
        check_eq("s5_count", {29'b0, count}, 32'd1);
        check_eq("s5_rd",    {31'b0, mem_bus.mem_rd}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        check_eq("s5_redir_ign", {29'b0, count}, 32'd1);
        check_eq("s5_head",      {16'b0, inst}, 32'h5678);
        dec_ready = 1'b1;
        tick();
        check_eq("s5_drained", {31'b0, inst_valid}, 32'd0);
        check_eq("s5_nop",     {16'b0, inst}, {16'b0, NopInst});
        tick();
        tick();
        check_eq("s5_still_rd", {31'b0, mem_bus.mem_rd}, 32'd0);
        check_eq("s5_sticky",   {31'b0, err}, 32'd1);

        // Only reset leaves FAULT.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst2_err", {31'b0, err}, 32'd0);
        tick();
        check_eq("rst2_rd",  {31'b0, mem_bus.mem_rd}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: the clock port is clk and the reset port is rst.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 16, instruction and PC width.
- DEPTH, 4, instruction queue entries; power of two, at least 2.
- NOP_INST, 16'h0800, instruction presented when the queue is empty.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- redirect, in, 1, jump or branch-mispredict redirect.
- redirect_pc, in, WIDTH, redirect target.
- halt, in, 1, createDump; stop issuing requests.
- mem_rd, out, 1, I-cache read request.
- mem_addr, out, WIDTH, request address.
- mem_stall, in, 1, cache busy.
- mem_done, in, 1, mem_data is valid this cycle.
- mem_data, in, WIDTH, fetched instruction.
- mem_err, in, 1, cache error for the current response.
- dec_ready, in, 1, decode accepts the head entry (low on a hazard stall).
- inst, out, WIDTH, head instruction, or NOP_INST when the queue is empty.
- inst_pc_inc, out, WIDTH, head PC+2.
- inst_valid, out, 1, queue not empty.
- count, out, clog2(DEPTH+1), occupancy.
- err, out, 1, sticky fault.

Function
REQ-004 The block SHALL use a state machine with four states: IDLE, REQ, DISCARD and FAULT.
REQ-005 In IDLE with count<DEPTH, halt=0 and no redirect, the block SHALL move to REQ on the next edge.
REQ-006 While in REQ or DISCARD, mem_rd SHALL be 1 and mem_addr SHALL equal the fetch PC (fpc); mem_rd SHALL be 0 in all other states.
REQ-007 In REQ, when mem_done=1 and mem_err=0, the block SHALL push {mem_data, fpc+2}, set fpc to fpc+2 and return to IDLE.
REQ-008 While mem_stall=1 and mem_done=0, the block SHALL hold its state and mem_addr.
REQ-009 The block SHALL allow only one request outstanding at a time; a response SHALL reach inst_valid one cycle after mem_done (no bypass).
REQ-010 The head entry SHALL pop when inst_valid=1, dec_ready=1 and redirect=0; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-011 On redirect, the block SHALL flush the queue (count=0) and set fpc to redirect_pc.
REQ-012 A redirect in REQ without mem_done SHALL move the block to DISCARD; in DISCARD, mem_done SHALL drop the data and return the block to IDLE.
REQ-013 A redirect in the same cycle as mem_done SHALL drop the data and move the block to IDLE; redirect has priority over push and pop.
REQ-014 redirect_pc[0]=1 SHALL set err and move the block to FAULT.
REQ-015 mem_done with mem_err=1 SHALL set err, push nothing and move the block to FAULT.
REQ-016 FAULT SHALL be left only by reset; redirect in FAULT SHALL be ignored, while already-queued entries SHALL still drain.
REQ-017 fpc+2 SHALL wrap modulo 2^WIDTH, so 16'hFFFE advances to 16'h0000 with no error.
REQ-018 halt SHALL block new requests only; an outstanding request SHALL complete and push.

Reset
REQ-019 With rst=1 at a clock edge, the block SHALL set state to IDLE, fpc to 0 and count to 0, and clear err.
REQ-020 Reset SHALL take priority over redirect and mem_done; a response arriving in the reset cycle SHALL be dropped.
REQ-021 In the cycle after reset, the outputs SHALL be: inst=NOP_INST, inst_valid=0, inst_pc_inc=0, mem_rd=0, err=0.

Structure
REQ-022 The state enum, NOP_INST and the default WIDTH/DEPTH SHALL be defined in a shared package fetch_pkg.
REQ-023 Queue storage SHALL be a sub-module inst_fifo: a circular buffer with wrapping read/write pointers, synchronous flush, and push/pop/count, storing inst and pc_inc together.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then a cache returning 16'h1111 at address 0 with 2-cycle stall, dec_ready=1 -> inst=16'h1111, inst_pc_inc=2, inst_valid=1 one cycle after mem_done.
- dec_ready=0 for 20 cycles -> exactly 4 entries queued, count=4, mem_rd=0 afterwards.
- Redirect to 16'h0040 while REQ is stalled -> state DISCARD, stale data dropped, next mem_addr=16'h0040, count=0.
- Redirect in the same cycle as mem_done -> no push; next request at the redirect target.
- mem_err=1 on a response -> err=1, no further mem_rd, queued entries still drain, NOP_INST shown once empty.
- fpc=16'hFFFE fetch completes -> next mem_addr=16'h0000, err stays 0.
